// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - two-requester round-robin APB master arbiter with wait-state timeout
module apb_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [4:0] ADDR0,
  input  logic [4:0] ADDR1,
  input  logic       WRITE0,
  input  logic       WRITE1,
  input  logic [7:0] WDATA0,
  input  logic [7:0] WDATA1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic       ERR0,
  output logic       ERR1,
  output logic [7:0] RDATA0,
  output logic [7:0] RDATA1,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t     state, state_d;
  logic       last, last_d, owner, owner_d;
  logic [7:0] wait_cnt, wait_cnt_d;
  logic       gnt0_d, gnt1_d, done0_d, done1_d, err0_d, err1_d;
  logic [7:0] rdata0_d, rdata1_d, pwdata_d;
  logic       psel_d, penable_d, pwrite_d;
  logic [4:0] paddr_d;
  logic       any_req, winner, grant, finish, abort;
  logic [7:0] result;

  assign any_req = REQ0 | REQ1;
  assign winner  = (REQ0 & REQ1) ? ~last : REQ1;

  always_comb begin
    state_d    = state;
    last_d     = last;
    owner_d    = owner;
    wait_cnt_d = wait_cnt;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err0_d     = ERR0;
    err1_d     = ERR1;
    rdata0_d   = RDATA0;
    rdata1_d   = RDATA1;
    psel_d     = PSEL;
    penable_d  = PENABLE;
    pwrite_d   = PWRITE;
    paddr_d    = PADDR;
    pwdata_d   = PWDATA;
    grant      = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    result     = 8'h00;

    case (state)
      IDLE: grant = any_req;
      SETUP: begin
        state_d    = ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = 8'h00;
      end
      ACCESS: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (PREADY) begin
          finish = 1'b1;
        end else if (TIMEOUT != 0 && ({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT)) begin
          finish = 1'b1;
          abort  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 8'd1;
        end
        if (finish) begin
          result = abort ? 8'h00 : PRDATA;
          if (owner) begin
            done1_d = 1'b1;
            err1_d  = abort;
            if (abort || !PWRITE) rdata1_d = result;
          end else begin
            done0_d = 1'b1;
            err0_d  = abort;
            if (abort || !PWRITE) rdata0_d = result;
          end
          if (any_req) begin
            grant = 1'b1;
          end else begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d   = SETUP;
      last_d    = winner;
      owner_d   = winner;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      gnt0_d    = ~winner;
      gnt1_d    = winner;
      paddr_d   = winner ? ADDR1  : ADDR0;
      pwrite_d  = winner ? WRITE1 : WRITE0;
      pwdata_d  = winner ? WDATA1 : WDATA0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      wait_cnt <= 8'h00;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      ERR0     <= 1'b0;
      ERR1     <= 1'b0;
      RDATA0   <= 8'h00;
      RDATA1   <= 8'h00;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= 5'h00;
      PWDATA   <= 8'h00;
    end else begin
      state    <= state_d;
      last     <= last_d;
      owner    <= owner_d;
      wait_cnt <= wait_cnt_d;
      GNT0     <= gnt0_d;
      GNT1     <= gnt1_d;
      DONE0    <= done0_d;
      DONE1    <= done1_d;
      ERR0     <= err0_d;
      ERR1     <= err1_d;
      RDATA0   <= rdata0_d;
      RDATA1   <= rdata1_d;
      PSEL     <= psel_d;
      PENABLE  <= penable_d;
      PWRITE   <= pwrite_d;
      PADDR    <= paddr_d;
      PWDATA   <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - self-checking bench for apb_arbiter (TIMEOUT 15, 0 and 1 instances)
`timescale 1ns/1ps
module tb_apb_arbiter;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  logic       REQ0 = 0, REQ1 = 0, WRITE0 = 0, WRITE1 = 0, PREADY = 0;
  logic [4:0] ADDR0 = 0, ADDR1 = 0;
  logic [7:0] WDATA0 = 0, WDATA1 = 0, PRDATA = 0;

  logic       GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, PSEL, PENABLE, PWRITE;
  logic [7:0] RDATA0, RDATA1, PWDATA;
  logic [4:0] PADDR;
  logic       a_gnt0, a_gnt1, a_done0, a_done1, a_err0, a_err1, a_psel, a_pen, a_pwr;
  logic [7:0] a_rd0, a_rd1, a_pwd;
  logic [4:0] a_pa;
  logic       b_gnt0, b_gnt1, b_done0, b_done1, b_err0, b_err1, b_psel, b_pen, b_pwr;
  logic [7:0] b_rd0, b_rd1, b_pwd;
  logic [4:0] b_pa;

  apb_arbiter #(.TIMEOUT(15)) d15 (
    .PCLK(PCLK), .PRESET(PRESET), .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WRITE0(WRITE0), .WRITE1(WRITE1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1), .ERR0(ERR0), .ERR1(ERR1),
    .RDATA0(RDATA0), .RDATA1(RDATA1), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY));

  apb_arbiter #(.TIMEOUT(0)) d0 (
    .PCLK(PCLK), .PRESET(PRESET), .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WRITE0(WRITE0), .WRITE1(WRITE1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(a_gnt0), .GNT1(a_gnt1), .DONE0(a_done0), .DONE1(a_done1), .ERR0(a_err0), .ERR1(a_err1),
    .RDATA0(a_rd0), .RDATA1(a_rd1), .PSEL(a_psel), .PENABLE(a_pen), .PWRITE(a_pwr),
    .PADDR(a_pa), .PWDATA(a_pwd), .PRDATA(PRDATA), .PREADY(PREADY));

  apb_arbiter #(.TIMEOUT(1)) d1 (
    .PCLK(PCLK), .PRESET(PRESET), .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WRITE0(WRITE0), .WRITE1(WRITE1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(b_gnt0), .GNT1(b_gnt1), .DONE0(b_done0), .DONE1(b_done1), .ERR0(b_err0), .ERR1(b_err1),
    .RDATA0(b_rd0), .RDATA1(b_rd1), .PSEL(b_psel), .PENABLE(b_pen), .PWRITE(b_pwr),
    .PADDR(b_pa), .PWDATA(b_pwd), .PRDATA(PRDATA), .PREADY(PREADY));

  int total = 0;
  int bad = 0;
  logic [7:0] rd_model [2];

  typedef struct {
    int         r;
    logic [4:0] a;
    logic       w;
    logic [7:0] wd;
    logic [7:0] pd;
    int         waits;
    int         e_dl;
    logic       e_err;
    logic [7:0] e_rd;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Latency of DONE measured in edges from the edge that first samples REQ.
  function automatic int exp_dl(input int waits, input int t);
    return (t != 0 && waits >= t) ? 2 + t : 3 + waits;
  endfunction

  task automatic do_reset();
    PRESET = 1'b1;
    REQ0 = 0; REQ1 = 0; PREADY = 0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
  endtask

  task automatic xfer(input int r, input logic [4:0] a, input logic w, input logic [7:0] wd,
                      input logic [7:0] pd, input int waits,
                      output int gl, output int dl, output logic [3:0] seq, output logic e,
                      output logic [7:0] rd, output logic stable, output logic other,
                      output logic ps);
    int k = 0;
    gl = -1; dl = -1; seq = 0; e = 0; rd = 0; stable = 1; other = 0; ps = 1;
    @(posedge PCLK); #1;
    PRDATA = pd; PREADY = 0;
    if (r == 0) begin REQ0 = 1; ADDR0 = a; WRITE0 = w; WDATA0 = wd; end
    else        begin REQ1 = 1; ADDR1 = a; WRITE1 = w; WDATA1 = wd; end
    for (int c = 1; c <= 400 && dl < 0; c++) begin
      @(posedge PCLK); #1;
      if (c == 1) seq[3:2] = {PSEL, PENABLE};
      if (c == 2) seq[1:0] = {PSEL, PENABLE};
      if ((r == 0 ? GNT0 : GNT1) && gl < 0) begin gl = c; REQ0 = 0; REQ1 = 0; end
      if (r == 0 ? (GNT1 | DONE1) : (GNT0 | DONE0)) other = 1;
      if (r == 0 ? DONE0 : DONE1) begin
        dl = c; e = (r == 0) ? ERR0 : ERR1; rd = (r == 0) ? RDATA0 : RDATA1; ps = PSEL;
      end
      if (PSEL && PENABLE) begin
        if (PADDR !== a || PWDATA !== wd || PWRITE !== w) stable = 0;
        PREADY = (k >= waits);
        k++;
      end else begin
        PREADY = 0;
      end
    end
    PREADY = 0;
  endtask

  initial begin
    int gl, dl;
    logic [3:0] seq;
    logic e, stable, other, ps, saw;
    logic [7:0] rd;
    int order [$];
    int exp_order [4];
    int dl15, dl0, dl1;
    logic e15, e0, e1, ps15;
    logic [7:0] r15, r0, r1;

    tbl[0] = '{0, 5'h18, 1'b0, 8'h00, 8'h42, 0,  3,  1'b0, 8'h42};
    tbl[1] = '{1, 5'h05, 1'b1, 8'hA5, 8'h00, 3,  6,  1'b0, 8'h00};
    tbl[2] = '{0, 5'h03, 1'b0, 8'h00, 8'hEE, 20, 17, 1'b1, 8'h00};
    tbl[3] = '{0, 5'h07, 1'b0, 8'h00, 8'h3C, 0,  3,  1'b0, 8'h3C};
    tbl[4] = '{1, 5'h1F, 1'b0, 8'h00, 8'h99, 14, 17, 1'b0, 8'h99};
    tbl[5] = '{0, 5'h0A, 1'b1, 8'h5C, 8'h00, 15, 17, 1'b1, 8'h00};
    exp_order = '{0, 1, 0, 1};

    do_reset();
    chk("reset_state", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, GNT0, GNT1, DONE0, DONE1,
                        ERR0, ERR1, RDATA0, RDATA1}, 0);

    for (int i = 0; i < 6; i++) begin
      xfer(tbl[i].r, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].pd, tbl[i].waits,
           gl, dl, seq, e, rd, stable, other, ps);
      chk($sformatf("v%0d_gnt_lat", i), gl, 1);
      chk($sformatf("v%0d_psel_seq", i), seq, 4'b1011);
      chk($sformatf("v%0d_done_lat", i), dl, tbl[i].e_dl);
      chk($sformatf("v%0d_err", i), e, tbl[i].e_err);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].e_rd);
      chk($sformatf("v%0d_stable", i), stable, 1);
      chk($sformatf("v%0d_other_quiet", i), other, 0);
      chk($sformatf("v%0d_psel_drop", i), ps, 0);
    end

    // Back-to-back contention, both requesters held high.
    do_reset();
    @(posedge PCLK); #1;
    REQ0 = 1; REQ1 = 1; ADDR0 = 5'h01; ADDR1 = 5'h02; WRITE0 = 0; WRITE1 = 0;
    PREADY = 1; PRDATA = 8'h11;
    saw = 1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge PCLK); #1;
      if (GNT0) order.push_back(0);
      if (GNT1) order.push_back(1);
      if (!PSEL) saw = 0;
    end
    REQ0 = 0; REQ1 = 0;
    repeat (3) @(posedge PCLK);
    #1 PREADY = 0;
    chk("b2b_grants", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("b2b_order%0d", i), order[i], exp_order[i]);
    chk("b2b_psel_held", saw, 1);
    chk("b2b_idle_after", PSEL, 0);

    // Hung slave seen by TIMEOUT=15, 0 and 1 instances at once.
    do_reset();
    dl15 = -1; dl0 = -1; dl1 = -1; e15 = 0; e0 = 1; e1 = 0; r15 = 8'hFF; r0 = 0; r1 = 8'hFF; ps15 = 1;
    begin
      int k = 0;
      @(posedge PCLK); #1;
      REQ0 = 1; ADDR0 = 5'h11; WRITE0 = 0; PRDATA = 8'h77; PREADY = 0;
      for (int c = 1; c <= 400 && dl0 < 0; c++) begin
        @(posedge PCLK); #1;
        if (GNT0) REQ0 = 0;
        if (DONE0 && dl15 < 0) begin dl15 = c; e15 = ERR0; r15 = RDATA0; ps15 = PSEL; end
        if (b_done0 && dl1 < 0) begin dl1 = c; e1 = b_err0; r1 = b_rd0; end
        if (a_done0) begin dl0 = c; e0 = a_err0; r0 = a_rd0; end
        if (a_psel && a_pen) begin PREADY = (k >= 300); k++; end
        else PREADY = 0;
      end
      PREADY = 0;
    end
    chk("to15_done_lat", dl15, exp_dl(300, 15));
    chk("to15_err", e15, 1);
    chk("to15_rdata", r15, 8'h00);
    chk("to15_psel_drop", ps15, 0);
    chk("to15_err_hold", ERR0, 1);
    chk("to1_done_lat", dl1, exp_dl(300, 1));
    chk("to1_err", e1, 1);
    chk("to1_rdata", r1, 8'h00);
    chk("to0_done_lat", dl0, exp_dl(300, 0));
    chk("to0_err", e0, 0);
    chk("to0_rdata", r0, 8'h77);
    xfer(0, 5'h04, 1'b0, 8'h00, 8'h6B, 2, gl, dl, seq, e, rd, stable, other, ps);
    chk("after_to_lat", dl, exp_dl(2, 15));
    chk("after_to_err", e, 0);
    chk("after_to_rdata", rd, 8'h6B);

    // Reset in the middle of ACCESS.
    do_reset();
    @(posedge PCLK); #1;
    REQ1 = 1; ADDR1 = 5'h09; WRITE1 = 0; PREADY = 0;
    @(posedge PCLK); #1;
    REQ1 = 0;
    repeat (2) @(posedge PCLK);
    #1 chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1 chk("rst_mid_drop", {PSEL, PENABLE, GNT1, DONE1}, 0);
    saw = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      if (c == 2) PRESET = 1'b0;
      if (DONE1 || DONE0) saw = 1;
    end
    chk("rst_no_done", saw, 0);
    xfer(1, 5'h0C, 1'b0, 8'h00, 8'h5A, 1, gl, dl, seq, e, rd, stable, other, ps);
    chk("post_rst_lat", dl, exp_dl(1, 15));
    chk("post_rst_err", e, 0);
    chk("post_rst_rdata", rd, 8'h5A);

    // Randomised single transfers against the reference model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int r, wt, ed;
      logic w;
      logic [4:0] a;
      logic [7:0] wd, pd;
      r  = $urandom_range(1, 0);
      w  = 1'($urandom_range(1, 0));
      a  = 5'($urandom);
      wd = 8'($urandom);
      pd = 8'($urandom);
      wt = $urandom_range(18, 0);
      ed = exp_dl(wt, 15);
      xfer(r, a, w, wd, pd, wt, gl, dl, seq, e, rd, stable, other, ps);
      if (wt >= 15) rd_model[r] = 8'h00;
      else if (!w) rd_model[r] = pd;
      chk($sformatf("r%0d_lat", i), dl, ed);
      chk($sformatf("r%0d_err", i), e, wt >= 15);
      chk($sformatf("r%0d_rdata", i), rd, rd_model[r]);
      chk($sformatf("r%0d_stable", i), stable, 1);
      chk($sformatf("r%0d_other_rdata", i), (r == 0) ? RDATA1 : RDATA0, rd_model[1-r]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
